// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed instruction loader.
package prog_loader_pkg;

   localparam int unsigned BYTES_PER_WORD    = 4;
   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHK,
      DONE,
      ERROR
   } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects little-endian bytes into a word and pulses word_complete_o
// one cycle after the last byte of each word.
module prog_loader_word_assembler
   import prog_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  byte_en_i,
   input  logic [7:0]            byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_complete_o,
   output logic                  last_slot_c
);

   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;

   assign last_slot_c = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

   // Shift right so the first byte of a word ends up in the low lane.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (byte_en_i) begin
         word_d = {byte_i, word_q[DATA_WIDTH-1:8]};
         cnt_d  = cnt_q + CNT_W'(1);
         done_d = last_slot_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign word_o          = word_q;
   assign word_complete_o = done_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, LEN_LO, LEN_HI, LEN words, XOR checksum;
// writes each assembled word to instruction memory at consecutive addresses.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
   localparam int unsigned WL_W      = $clog2(MEM_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   input  logic                  restart,
   output logic                  prog_ready,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  load_done,
   output logic                  load_error,
   output logic [WL_W-1:0]       words_loaded
);

   state_e                state_q, state_d;
   logic [7:0]            chk_q, chk_d;
   logic [15:0]           len_q, len_d;
   logic [WL_W-1:0]       words_q, words_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic                  byte_ready_q, byte_ready_d;
   logic                  prog_ready_q, prog_ready_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic        xfer_c;
   logic        sync_c;
   logic        data_byte_c;
   logic        last_slot_c;
   logic [15:0] len_full_c;

   assign xfer_c      = byte_valid && byte_ready_q;
   assign sync_c      = (state_q == IDLE) && xfer_c && (byte_data == SYNC_BYTE);
   assign data_byte_c = (state_q == DATA) && xfer_c;
   assign len_full_c  = {byte_data, len_q[7:0]};

   prog_loader_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_asm (
      .clk             (clk),
      .rst             (rst),
      .clr_i           (sync_c),
      .byte_en_i       (data_byte_c),
      .byte_i          (byte_data),
      .word_o          (instruction),
      .word_complete_o (w_en),
      .last_slot_c     (last_slot_c)
   );

   // Next-state, checksum, length and address bookkeeping.
   always_comb begin
      state_d  = state_q;
      chk_d    = chk_q;
      len_d    = len_q;
      words_d  = words_q;
      w_addr_d = w_addr_q;
      done_d   = done_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (sync_c) begin
               state_d = LEN_LO;
               chk_d   = '0;
               len_d   = '0;
               words_d = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         LEN_LO: begin
            if (xfer_c) begin
               len_d   = {8'h00, byte_data};
               chk_d   = chk_q ^ byte_data;
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer_c) begin
               len_d = len_full_c;
               chk_d = chk_q ^ byte_data;
               if (len_full_c > 16'(MEM_DEPTH)) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end else if (len_full_c == 16'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer_c) begin
               chk_d = chk_q ^ byte_data;
               if (last_slot_c) begin
                  w_addr_d = ADDR_WIDTH'(words_q) * ADDR_WIDTH'(BYTES_PER_WORD);
                  words_d  = words_q + WL_W'(1);
                  if (16'(words_q) + 16'd1 == len_q) begin
                     state_d = CHK;
                  end
               end
            end
         end
         CHK: begin
            if (xfer_c) begin
               if (byte_data == chk_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         DONE, ERROR: begin
            if (restart) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      byte_ready_d = (state_d != DONE) && (state_d != ERROR);
      prog_ready_d = (state_d != IDLE) && (state_d != DONE) && (state_d != ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         chk_q        <= '0;
         len_q        <= '0;
         words_q      <= '0;
         w_addr_q     <= '0;
         byte_ready_q <= 1'b1;
         prog_ready_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         chk_q        <= chk_d;
         len_q        <= len_d;
         words_q      <= words_d;
         w_addr_q     <= w_addr_d;
         byte_ready_q <= byte_ready_d;
         prog_ready_q <= prog_ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready   = byte_ready_q;
   assign prog_ready   = prog_ready_q;
   assign w_addr       = w_addr_q;
   assign load_done    = done_q;
   assign load_error   = err_q;
   assign words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the microprocessor's instruction-programming interface (prog_ready / w_en / instruction).
- Receives a framed byte stream from a host link, for example a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them to instruction memory at consecutive word addresses.
- Validates length and checksum. Holds the core in programming mode while a frame is in flight.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.
- MEM_DEPTH, 64, instruction memory depth in words; maximum legal frame length.
- ADDR_WIDTH, 32, width of the byte address driven to memory.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming stream byte.
- byte_ready  out  1  loader accepts a byte; a transfer happens when byte_valid && byte_ready.
- restart  in  1  one-cycle pulse; leaves DONE/ERROR and returns to IDLE.
- prog_ready  out  1  programming mode; high from SYNC accepted until DONE/ERROR.
- w_en  out  1  one-cycle instruction memory write strobe.
- w_addr  out  ADDR_WIDTH  byte address of the write, equal to word_index*4.
- instruction  out  DATA_WIDTH  word being written.
- load_done  out  1  sticky; frame loaded and checksum matched.
- load_error  out  1  sticky; length or checksum failure.
- words_loaded  out  $clog2(MEM_DEPTH+1)  number of words written in the current frame.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except byte_ready=1.
  - Byte counter, word counter, length, checksum and partial word are cleared.
  - A partially assembled word is discarded; no w_en is produced.
  - Reset applies in any state and dominates byte_valid and restart.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, LEN×4 data bytes (LSB first per word), CHK.
  - CHK is the XOR of LEN_LO, LEN_HI and all data bytes.
- FSM states:
  - IDLE:
    - byte_ready=1.
    - A byte equal to SYNC_BYTE goes to LEN_LO, sets prog_ready=1 and clears checksum, counters, load_done and load_error.
    - Any other byte is consumed and dropped.
  - LEN_LO: capture the low length byte and XOR it into the checksum, then go to LEN_HI.
  - LEN_HI: capture the high length byte and XOR it into the checksum, then branch:
    - length > MEM_DEPTH goes to ERROR.
    - length == 0 goes to CHK.
    - Otherwise go to DATA.
  - DATA:
    - Shift byte k (k = 0..3) into instruction[8k+7:8k] and XOR it into the checksum.
    - On the transfer of byte 3, w_en=1 in the next cycle, with instruction = assembled word and w_addr = words_loaded*4.
    - words_loaded increments in that same cycle.
    - byte_ready stays 1; the memory absorbs one write per cycle, so no stall.
    - After the last word's byte 3, go to CHK.
  - CHK:
    - Byte equal to the running checksum goes to DONE.
    - Mismatch goes to ERROR.
  - DONE: byte_ready=0, prog_ready=0, load_done=1.
  - ERROR: byte_ready=0, prog_ready=0, load_error=1.
  - DONE and ERROR are exited only by restart=1, which goes to IDLE. load_done and load_error hold until the next SYNC accept.
- restart has no effect in any state other than DONE or ERROR.
- Cycles with byte_valid=0 change no state; gaps are allowed anywhere in a frame.
- Words written before an ERROR are not rolled back. load_error signals that memory contents are invalid.
- w_addr wraps never; the MEM_DEPTH check guarantees the maximum is (MEM_DEPTH-1)*4.
- Latency: w_en occurs 1 cycle after the 4th byte handshake. prog_ready falls 1 cycle after the CHK byte handshake.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR);
  - SYNC_BYTE_DEFAULT;
  - a BYTES_PER_WORD=4 constant.
- One natural sub-module, word_assembler: byte shift register, 2-bit byte counter and word_complete pulse.
- FSM, checksum and address counter stay in prog_loader.

Test Plan:
- Single word: stream A5 01 00 93 00 50 00 C2 -> one w_en with w_addr=0, instruction=0x00500093; then load_done=1, prog_ready=0, words_loaded=1.
- Two words with byte_valid gaps of 0–3 random idle cycles: stream A5 02 00 93 00 50 00 33 81 10 00 63 -> writes (0, 0x00500093) and (4, 0x00108133); load_done=1.
- Bad checksum: same single-word frame with final byte 0xC3 -> one w_en, then load_error=1, load_done=0, byte_ready=0; a restart pulse returns byte_ready=1.
- Length overflow: stream A5 41 00 with MEM_DEPTH=64 -> ERROR immediately after LEN_HI, no w_en, load_error=1.
- Zero length and garbage: stream 00 FF A5 00 00 00 -> leading bytes dropped in IDLE, no w_en, load_done=1, words_loaded=0.
- Reset mid-word: A5 01 00 93 00, then rst for 1 cycle, then the full single-word frame -> no w_en before reset; all outputs 0 after reset; exactly one write (0, 0x00500093).
